// File: rtl/keypad_entry_pkg.sv
// Shared definitions for the keypad entry block: scanner key codes, the
// key-class enum produced by the decoder, and the entry FSM state encoding.
package keypad_entry_pkg;

    // Raw 4-bit codes delivered by the keypad scanner.
    localparam logic [3:0] KEY_1    = 4'b0001;
    localparam logic [3:0] KEY_2    = 4'b0010;
    localparam logic [3:0] KEY_3    = 4'b0011;
    localparam logic [3:0] KEY_4    = 4'b0101;
    localparam logic [3:0] KEY_5    = 4'b0110;
    localparam logic [3:0] KEY_6    = 4'b0111;
    localparam logic [3:0] KEY_7    = 4'b1001;
    localparam logic [3:0] KEY_8    = 4'b1010;
    localparam logic [3:0] KEY_9    = 4'b1011;
    localparam logic [3:0] KEY_0    = 4'b1110;
    localparam logic [3:0] KEY_STAR = 4'b1101;
    localparam logic [3:0] KEY_HASH = 4'b1111;
    localparam logic [3:0] KEY_A    = 4'b0100;
    localparam logic [3:0] KEY_B    = 4'b1000;
    localparam logic [3:0] KEY_C    = 4'b1100;
    localparam logic [3:0] KEY_D    = 4'b0000;

    // What a key means to the entry logic.
    typedef enum logic [1:0] {
        KC_DIGIT = 2'd0,
        KC_CLEAR = 2'd1,
        KC_ENTER = 2'd2,
        KC_FUNC  = 2'd3
    } key_class_e;

    // Entry FSM states. IDLE holds no digits, ENTRY holds a partial code,
    // HOLD presents a completed code until the consumer takes it.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/keycode_decoder.sv
// Combinational key-code decoder: classifies a scanner code and extracts
// its BCD digit value or function index. Shared with the display logic.
module keycode_decoder
    import keypad_entry_pkg::*;
(
    input  logic [3:0]  key_value_i,
    output key_class_e  key_class_o,
    output logic [3:0]  digit_o,
    output logic [1:0]  func_o
);

    // Full 16-entry code map; digit/func are zero when not meaningful.
    always_comb begin
        key_class_o = KC_FUNC;
        digit_o     = 4'd0;
        func_o      = 2'd0;
        case (key_value_i)
            KEY_1:    begin key_class_o = KC_DIGIT; digit_o = 4'd1; end
            KEY_2:    begin key_class_o = KC_DIGIT; digit_o = 4'd2; end
            KEY_3:    begin key_class_o = KC_DIGIT; digit_o = 4'd3; end
            KEY_4:    begin key_class_o = KC_DIGIT; digit_o = 4'd4; end
            KEY_5:    begin key_class_o = KC_DIGIT; digit_o = 4'd5; end
            KEY_6:    begin key_class_o = KC_DIGIT; digit_o = 4'd6; end
            KEY_7:    begin key_class_o = KC_DIGIT; digit_o = 4'd7; end
            KEY_8:    begin key_class_o = KC_DIGIT; digit_o = 4'd8; end
            KEY_9:    begin key_class_o = KC_DIGIT; digit_o = 4'd9; end
            KEY_0:    begin key_class_o = KC_DIGIT; digit_o = 4'd0; end
            KEY_STAR: key_class_o = KC_CLEAR;
            KEY_HASH: key_class_o = KC_ENTER;
            KEY_A:    begin key_class_o = KC_FUNC; func_o = 2'd0; end
            KEY_B:    begin key_class_o = KC_FUNC; func_o = 2'd1; end
            KEY_C:    begin key_class_o = KC_FUNC; func_o = 2'd2; end
            KEY_D:    begin key_class_o = KC_FUNC; func_o = 2'd3; end
            default:  key_class_o = KC_FUNC;
        endcase
    end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry: turns the scanner's raw key stream into one event per
// physical press, assembles multi-digit BCD codes handed to the vending
// controller over valid/ready, and forwards A-D as function pulses.
//
// Handshake: code_valid rises with a completed code and stays high, with
// entry_code/digit_count stable, until an edge where code_ready is also
// high; that edge is the transfer. code_ready is ignored while code_valid
// is low.
//
// Timing: a key is accepted at the edge where armed and key_pressed are
// both high; the accepted code is registered there and acted on at the
// following edge, so all of its effects appear on outputs after edge t+1.
module keypad_entry
    import keypad_entry_pkg::*;
#(
    parameter int DIGITS         = 3,
    parameter int RELEASE_CYCLES = 250000,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [3:0]                   key_value,
    input  logic                         key_pressed,
    output logic                         code_valid,
    input  logic                         code_ready,
    output logic [4*DIGITS-1:0]          entry_code,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         func_valid,
    output logic [1:0]                   func_code,
    output logic                         entry_error,
    output logic                         entry_timeout,
    output state_e                       state_o,
    output logic                         armed_o
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int RW = (RELEASE_CYCLES > 2) ? $clog2(RELEASE_CYCLES) : 1;
    localparam int IW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    // Arming / release holdoff and the one-deep accepted-key register.
    logic          armed_q, armed_d;
    logic [RW-1:0] rel_cnt_q, rel_cnt_d;
    logic          evt_valid_q, evt_valid_d;
    logic [3:0]    evt_value_q, evt_value_d;
    logic          accept;

    // Entry FSM and its registered outputs.
    state_e              state_q, state_d;
    logic [IW-1:0]       idle_cnt_q, idle_cnt_d;
    logic [4*DIGITS-1:0] code_q, code_d;
    logic [CW-1:0]       count_q, count_d;
    logic                code_valid_q, code_valid_d;
    logic                func_valid_q, func_valid_d;
    logic [1:0]          func_code_q, func_code_d;
    logic                error_q, error_d;
    logic                timeout_q, timeout_d;

    // Decoded view of the accepted key.
    key_class_e evt_class;
    logic [3:0] evt_digit;
    logic [1:0] evt_func;

    keycode_decoder u_decoder (
        .key_value_i (evt_value_q),
        .key_class_o (evt_class),
        .digit_o     (evt_digit),
        .func_o      (evt_func)
    );

    // Accept a key when armed; re-arm only after RELEASE_CYCLES quiet cycles
    // so the scanner's per-slot toggling of key_pressed cannot re-trigger.
    always_comb begin
        accept      = armed_q && key_pressed;
        armed_d     = armed_q;
        rel_cnt_d   = rel_cnt_q;
        evt_valid_d = accept;
        evt_value_d = evt_value_q;
        if (accept) begin
            armed_d     = 1'b0;
            rel_cnt_d   = '0;
            evt_value_d = key_value;
        end else if (!armed_q) begin
            if (key_pressed) begin
                rel_cnt_d = '0;
            end else if (rel_cnt_q == RW'(RELEASE_CYCLES - 1)) begin
                armed_d   = 1'b1;
                rel_cnt_d = '0;
            end else begin
                rel_cnt_d = rel_cnt_q + RW'(1);
            end
        end
    end

    // Arming state and accepted-key register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            armed_q     <= 1'b1;
            rel_cnt_q   <= '0;
            evt_valid_q <= 1'b0;
            evt_value_q <= 4'd0;
        end else begin
            armed_q     <= armed_d;
            rel_cnt_q   <= rel_cnt_d;
            evt_valid_q <= evt_valid_d;
            evt_value_q <= evt_value_d;
        end
    end

    // Entry FSM next state and outputs; pulses default low every cycle.
    always_comb begin
        state_d      = state_q;
        idle_cnt_d   = '0;
        code_d       = code_q;
        count_d      = count_q;
        code_valid_d = code_valid_q;
        func_valid_d = 1'b0;
        func_code_d  = func_code_q;
        error_d      = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (evt_valid_q) begin
                    case (evt_class)
                        KC_DIGIT: begin
                            code_d  = {{(4*DIGITS-4){1'b0}}, evt_digit};
                            count_d = CW'(1);
                            state_d = ST_ENTRY;
                        end
                        KC_ENTER: error_d = 1'b1;
                        KC_FUNC: begin
                            func_valid_d = 1'b1;
                            func_code_d  = evt_func;
                        end
                        default: ;
                    endcase
                end
            end

            ST_ENTRY: begin
                if (evt_valid_q) begin
                    // Any accepted key restarts the inactivity window and
                    // takes precedence over a timeout in the same cycle.
                    idle_cnt_d = '0;
                    case (evt_class)
                        KC_DIGIT: begin
                            if (count_q < CW'(DIGITS)) begin
                                code_d  = {code_q[4*DIGITS-5:0], evt_digit};
                                count_d = count_q + CW'(1);
                            end else begin
                                error_d = 1'b1;
                            end
                        end
                        KC_CLEAR: begin
                            code_d  = '0;
                            count_d = '0;
                            state_d = ST_IDLE;
                        end
                        KC_ENTER: begin
                            code_valid_d = 1'b1;
                            state_d      = ST_HOLD;
                        end
                        KC_FUNC: begin
                            func_valid_d = 1'b1;
                            func_code_d  = evt_func;
                        end
                        default: ;
                    endcase
                end else if (idle_cnt_q == IW'(TIMEOUT_CYCLES - 1)) begin
                    code_d    = '0;
                    count_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end
            end

            ST_HOLD: begin
                // Keys accepted here are swallowed; only the handshake moves on.
                if (code_valid_q && code_ready) begin
                    code_valid_d = 1'b0;
                    code_d       = '0;
                    count_d      = '0;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                code_valid_d = 1'b0;
                code_d       = '0;
                count_d      = '0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // Entry FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            idle_cnt_q   <= '0;
            code_q       <= '0;
            count_q      <= '0;
            code_valid_q <= 1'b0;
            func_valid_q <= 1'b0;
            func_code_q  <= 2'd0;
            error_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            code_q       <= code_d;
            count_q      <= count_d;
            code_valid_q <= code_valid_d;
            func_valid_q <= func_valid_d;
            func_code_q  <= func_code_d;
            error_q      <= error_d;
            timeout_q    <= timeout_d;
        end
    end

    assign code_valid    = code_valid_q;
    assign entry_code    = code_q;
    assign digit_count   = count_q;
    assign func_valid    = func_valid_q;
    assign func_code     = func_code_q;
    assign entry_error   = error_q;
    assign entry_timeout = timeout_q;
    assign state_o       = state_q;
    assign armed_o       = armed_q;

endmodule
